// File: rtl/fetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_buffer_pkg
//   Shared types and constants for the instruction fetch buffer.
//   - nop                   : canonical RISC-V nop (addi x0,x0,0), shown as a bubble
//   - fetch_depth           : default queue depth / outstanding request limit
//   - fetch_buffer_in_type  : imem handshake, redirect and decode-ready inputs
//   - fetch_buffer_out_type : imem request and decode-facing outputs
//   - word_align()          : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_buffer_pkg;

  localparam logic [31:0] nop         = 32'h0000_0013;
  localparam int          fetch_depth = 4;

  typedef struct packed {
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
  } fetch_buffer_in_type;

  typedef struct packed {
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
  } fetch_buffer_out_type;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch entries ({pc, instr}, optionally a flag bit).
//   clear has priority over pop; a push in the clear cycle becomes the sole
//   entry. A pop on an empty FIFO or a push on a full FIFO without a
//   simultaneous pop is ignored.
// Ports
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push/push_data, pop, clear : queue controls
//   count        : number of stored entries (0..DEPTH)
//   head_valid   : count != 0
//   head_data    : entry at the read pointer (stale when head_valid=0)
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int               DEPTH      = 4,
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int             AW         = $clog2(DEPTH);
  localparam int             CW         = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_DATA;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      if (push) begin
        mem_r[0] <= push_data;
        wr_ptr_r <= PTR_ONE;
        count_r  <= CW'(1);
      end else begin
        wr_ptr_r <= '0;
        count_r  <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign count      = count_r;
  assign head_valid = (count_r != '0);
  assign head_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction fetch stage with prefetch queue feeding decode. Issues
//   in-order word requests, buffers returned words with their PC, presents
//   one instruction per cycle and flushes on redirect. Responses still in
//   flight at a redirect are counted in discard and dropped on arrival.
// Ports
//   clock, reset                    : rising-edge clock, async active-high reset
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_rsp_valid/data             : in-order response channel
//   redirect_valid/pc               : flush and restart fetch
//   out_valid/ready/instr/pc        : head of queue towards decode
//   out_misalign (optional)         : head entry marks a misaligned redirect
// Configuration
//   FETCH_BUFFER_MISALIGN_EXC_EN : when defined, a misaligned redirect pushes a
//   single flagged nop entry and halts fetch until the next redirect; when
//   undefined, the redirect PC is word aligned.
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = fetch_depth,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIS_W = $clog2(2 * DEPTH + 1);
`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
  localparam int ENTRY_W = 65;
`else
  localparam int ENTRY_W = 64;
`endif
  localparam logic [CNT_W:0]       DEPTH_CREDIT  = (CNT_W + 1)'(DEPTH);
  localparam logic [DIS_W-1:0]     DISCARD_LIMIT = DIS_W'(DEPTH);
  localparam logic [ENTRY_W-1:0]   RESET_ENTRY   = ENTRY_W'({RESET_PC, nop});

  fetch_buffer_in_type  in_s;
  fetch_buffer_out_type out_s;

  logic [31:0]        fetch_pc_r,  fetch_pc_nxt_s;
  logic [31:0]        rsp_pc_r,    rsp_pc_nxt_s;
  logic [CNT_W-1:0]   inflight_r,  inflight_nxt_s;
  logic [DIS_W-1:0]   discard_r,   discard_nxt_s;
  logic [DIS_W-1:0]   outstanding_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               head_valid_s;
  logic [ENTRY_W-1:0] head_data_s;
  logic [ENTRY_W-1:0] push_data_s;
  logic               push_s;
  logic               pop_s;
  logic               credit_s;
  logic               req_valid_s;
  logic               accept_s;
  logic               rsp_push_s;
  logic               fetch_halt_s;

  assign in_s = '{imem_req_ready: imem_req_ready,
                  imem_rsp_valid: imem_rsp_valid,
                  imem_rsp_data:  imem_rsp_data,
                  redirect_valid: redirect_valid,
                  redirect_pc:    redirect_pc,
                  out_ready:      out_ready};

  // Queue entries plus requests in flight never exceed DEPTH, so a push always fits.
  assign credit_s = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < DEPTH_CREDIT;

  // Holding requests while discard exceeds DEPTH bounds discard at 2*DEPTH
  // under any sequence of redirects, so the counter cannot wrap.
  assign req_valid_s = credit_s && (discard_r <= DISCARD_LIMIT) && !fetch_halt_s
                       && !in_s.redirect_valid && !reset;
  assign accept_s    = req_valid_s && in_s.imem_req_ready;

  // A response is kept only when nothing is pending discard and it is not
  // coincident with a redirect.
  assign rsp_push_s = in_s.imem_rsp_valid && (discard_r == '0) && (inflight_r != '0)
                      && !in_s.redirect_valid;
  assign pop_s      = head_valid_s && in_s.out_ready && !in_s.redirect_valid;

  // Every response still owed by imem, used when a redirect turns all of them stale.
  assign outstanding_s = discard_r + DIS_W'(inflight_r);

`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
  logic halted_r;
  logic mis_redirect_s;

  assign mis_redirect_s = in_s.redirect_valid && (in_s.redirect_pc[1:0] != 2'b00);
  assign fetch_halt_s   = halted_r;
  assign push_s         = rsp_push_s || mis_redirect_s;
  assign push_data_s    = mis_redirect_s ? {1'b1, in_s.redirect_pc, nop}
                                         : {1'b0, rsp_pc_r, in_s.imem_rsp_data};
`else
  assign fetch_halt_s   = 1'b0;
  assign push_s         = rsp_push_s;
  assign push_data_s    = {rsp_pc_r, in_s.imem_rsp_data};
`endif

  // Next-state for the PC registers and the inflight/discard counters
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    rsp_pc_nxt_s   = rsp_pc_r;
    inflight_nxt_s = inflight_r;
    discard_nxt_s  = discard_r;
    if (in_s.redirect_valid) begin
      fetch_pc_nxt_s = word_align(in_s.redirect_pc);
      rsp_pc_nxt_s   = word_align(in_s.redirect_pc);
      inflight_nxt_s = '0;
      if (in_s.imem_rsp_valid && (outstanding_s != '0)) begin
        discard_nxt_s = outstanding_s - DIS_W'(1);
      end else begin
        discard_nxt_s = outstanding_s;
      end
    end else begin
      if (accept_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (rsp_push_s) begin
        rsp_pc_nxt_s = rsp_pc_r + 32'd4;
      end else begin
        rsp_pc_nxt_s = rsp_pc_r;
      end
      inflight_nxt_s = inflight_r + CNT_W'(accept_s) - CNT_W'(rsp_push_s);
      if (in_s.imem_rsp_valid && (discard_r != '0)) begin
        discard_nxt_s = discard_r - DIS_W'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
    end
  end

  // Fetch state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      inflight_r <= '0;
      discard_r  <= '0;
`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
      halted_r   <= 1'b0;
`endif
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      rsp_pc_r   <= rsp_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      discard_r  <= discard_nxt_s;
`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
      if (in_s.redirect_valid) begin
        halted_r <= mis_redirect_s;
      end else begin
        halted_r <= halted_r;
      end
`endif
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (ENTRY_W),
    .RESET_DATA (RESET_ENTRY)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .clear      (in_s.redirect_valid),
    .count      (fifo_count_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  // Head fields come straight from queue registers; an empty queue shows a nop.
  assign out_s = '{imem_req_valid: req_valid_s,
                   imem_req_addr:  fetch_pc_r,
                   out_valid:      head_valid_s,
                   out_instr:      head_valid_s ? head_data_s[31:0] : nop,
                   out_pc:         head_data_s[63:32]};

  assign imem_req_valid = out_s.imem_req_valid;
  assign imem_req_addr  = out_s.imem_req_addr;
  assign out_valid      = out_s.out_valid;
  assign out_instr      = out_s.out_instr;
  assign out_pc         = out_s.out_pc;
`ifdef FETCH_BUFFER_MISALIGN_EXC_EN
  assign out_misalign   = head_valid_s && head_data_s[64];
`endif

endmodule
